// File: rtl/fp_multiplier.sv
// Sequential IEEE754 single multiplier (24-step shift-and-add, DAZ, round-half-up on guard); start to done in 28 cycles, start ignored while busy.
// Define FP_MUL_SPECIAL_EN to give NaN/infinity inputs IEEE special-case results instead of the overflow path.
module fp_multiplier #(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_start,
    input  logic [31:0] inputa_754,
    input  logic [31:0] inputb_754,
    output logic        mul_busy,
    output logic [31:0] mul_result_754,
    output logic        mul_done
);

    localparam int PW    = 2 * MANT_W;
    localparam int FW    = MANT_W - 1;
    localparam int CNT_W = $clog2(MANT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        INIT = 5'b00010,
        EXE  = 5'b00100,
        NORM = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [MANT_W-1:0]  ma_q, ma_d, mb_q, mb_d;
    logic signed [9:0]  esum_q, esum_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic [31:0]        result_q, result_d;
`ifdef FP_MUL_SPECIAL_EN
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
`endif

    logic [FW-1:0]      frac_pre, frac_rnd;
    logic               guard, carry;
    logic signed [9:0]  esum_n;
    logic [31:0]        norm_res;

    // Normalise the product and pick the packed result from the latched flags.
    always_comb begin
        frac_pre = prod_q[PW-1] ? prod_q[PW-2 -: FW] : prod_q[PW-3 -: FW];
        guard    = prod_q[PW-1] ? prod_q[PW-2-FW]    : prod_q[PW-3-FW];
        esum_n   = esum_q + (prod_q[PW-1] ? 10'sd1 : 10'sd0);
        {carry, frac_rnd} = {1'b0, frac_pre} + {{FW{1'b0}}, guard};
        if (carry) begin
            esum_n = esum_n + 10'sd1;
        end
        norm_res = {sign_q, esum_n[7:0], frac_rnd};
`ifdef FP_MUL_SPECIAL_EN
        if (nan_q || (inf_q && zero_q)) begin
            norm_res = 32'h7FC0_0000;
        end else if (inf_q) begin
            norm_res = {sign_q, 8'hFF, 23'b0};
        end else
`endif
        if (zero_q) begin
            norm_res = {sign_q, 31'b0};
        end else if (esum_n >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'b0};
        end else if (esum_n <= 10'sd0) begin
            norm_res = {sign_q, 31'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        esum_d   = esum_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        result_d = result_q;
`ifdef FP_MUL_SPECIAL_EN
        nan_d    = nan_q;
        inf_d    = inf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                sign_d  = inputa_754[31] ^ inputb_754[31];
                ma_d    = {1'b1, inputa_754[FW-1:0]};
                mb_d    = {1'b1, inputb_754[FW-1:0]};
                esum_d  = $signed({2'b00, inputa_754[30:23]}) + $signed({2'b00, inputb_754[30:23]})
                          - $signed(10'(EXP_BIAS));
                zero_d  = (inputa_754[30:23] == 8'h00) || (inputb_754[30:23] == 8'h00);
`ifdef FP_MUL_SPECIAL_EN
                nan_d   = ((inputa_754[30:23] == 8'hFF) && (inputa_754[22:0] != 23'b0)) ||
                          ((inputb_754[30:23] == 8'hFF) && (inputb_754[22:0] != 23'b0));
                inf_d   = ((inputa_754[30:23] == 8'hFF) && (inputa_754[22:0] == 23'b0)) ||
                          ((inputb_754[30:23] == 8'hFF) && (inputb_754[22:0] == 23'b0));
`endif
                cnt_d   = '0;
                prod_d  = '0;
                state_d = EXE;
            end
            EXE: begin
                // mb is shifted left so its MSB is always mb[MANT_W-1-cnt] of the original.
                prod_d = {prod_q[PW-2:0], 1'b0} + (mb_q[MANT_W-1] ? {{MANT_W{1'b0}}, ma_q} : {PW{1'b0}});
                mb_d   = {mb_q[MANT_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                result_d = norm_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            esum_q   <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
`ifdef FP_MUL_SPECIAL_EN
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            esum_q   <= esum_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            result_q <= result_d;
`ifdef FP_MUL_SPECIAL_EN
            nan_q    <= nan_d;
            inf_q    <= inf_d;
`endif
        end
    end

    assign mul_busy       = (state_q != IDLE);
    assign mul_done       = (state_q == DONE);
    assign mul_result_754 = result_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed bench for fp_multiplier: latency, arithmetic vectors, start held high, mid-operation reset.
module tb_fp_multiplier;

    logic        clk;
    logic        rst;
    logic        mul_start;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mul_busy;
    logic [31:0] mul_result_754;
    logic        mul_done;

    int n_assert = 0;
    int n_fail   = 0;

    fp_multiplier dut (
        .clk           (clk),
        .rst           (rst),
        .mul_start     (mul_start),
        .inputa_754    (opa),
        .inputb_754    (opb),
        .mul_busy      (mul_busy),
        .mul_result_754(mul_result_754),
        .mul_done      (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a posedge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int k;
        mul_start = 1'b1;
        opa = a;
        opb = b;
        @(posedge clk); #1;
        mul_start = 1'b0;
        @(posedge clk); #1;
        opa = $urandom;
        opb = $urandom;
        k = 0;
        while (!mul_done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_done"}, {31'b0, mul_done}, 32'd1);
        check(tag, mul_result_754, exp);
        @(posedge clk); #1;
    endtask

    logic [31:0] exp_b2b [3];
    logic [31:0] op_a_b2b[3];
    logic [31:0] op_b_b2b[3];
    int first_done, busy_drops, n_done, extra;

    initial begin
        rst = 1'b1;
        mul_start = 1'b0;
        opa = '0;
        opb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, mul_busy}, 32'd0);
        check("rst_done", {31'b0, mul_done}, 32'd0);
        check("rst_result", mul_result_754, 32'h0);
        rst = 1'b0;

        // Latency: start presented in the cycle beginning at edge E0 (k=0).
        @(posedge clk); #1;
        mul_start = 1'b1;
        opa = 32'h3FC0_0000;
        opb = 32'h4000_0000;
        first_done = -1;
        busy_drops = 0;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            if (k == 1) mul_start = 1'b0;
            if (k == 2) begin opa = $urandom; opb = $urandom; end
            if (mul_done && first_done < 0) first_done = k;
            if (k <= 27 && !mul_busy) busy_drops++;
            if (k == 26) check("t1_result_before", mul_result_754, 32'h0);
            if (k == 27) check("t1_result", mul_result_754, 32'h4040_0000);
        end
        check("t1_done_edge", first_done, 32'd27);
        check("t1_busy_held", busy_drops, 32'd0);
        check("t1_done_pulse_end", {31'b0, mul_done}, 32'd0);
        check("t1_idle_after", {31'b0, mul_busy}, 32'd0);

        run_op("neg_half",   32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000);
        run_op("lsb_sq",     32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_op("guard_rnd",  32'h3FC0_0001, 32'h3FC0_0000, 32'h4010_0001);
        run_op("pi_x2",      32'h4049_0FDB, 32'h4000_0000, 32'h40C9_0FDB);
        repeat (3) @(posedge clk);
        #1;
        check("result_held", mul_result_754, 32'h40C9_0FDB);
        run_op("neg_neg",    32'hC000_0000, 32'hC040_0000, 32'h40C0_0000);
        run_op("neg_zero",   32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        run_op("denorm_ftz", 32'h0000_0001, 32'h4049_0FDB, 32'h0000_0000);
        run_op("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        run_op("esum_zero",  32'h2000_0000, 32'h1F80_0000, 32'h0000_0000);
        run_op("esum_one",   32'h2000_0000, 32'h2000_0000, 32'h0080_0000);
        run_op("esum_254",   32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000);
        run_op("overflow",   32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
        run_op("ninf_x1",    32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
`ifdef FP_MUL_SPECIAL_EN
        run_op("inf_x0",     32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_op("nan_x1",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
`else
        run_op("inf_x0",     32'h7F80_0000, 32'h0000_0000, 32'h0000_0000);
        run_op("nan_x1",     32'h7FC0_0001, 32'h3F80_0000, 32'h7F80_0000);
`endif

        // Start held high: operands are valid only in each INIT cycle (k = 28n+1).
        op_a_b2b[0] = 32'h4000_0000; op_b_b2b[0] = 32'h4040_0000; exp_b2b[0] = 32'h40C0_0000;
        op_a_b2b[1] = 32'hBF80_0000; op_b_b2b[1] = 32'h4049_0FDB; exp_b2b[1] = 32'hC049_0FDB;
        op_a_b2b[2] = 32'h3FC0_0001; op_b_b2b[2] = 32'h3FC0_0000; exp_b2b[2] = 32'h4010_0001;
        n_done = 0;
        mul_start = 1'b1;
        opa = $urandom;
        opb = $urandom;
        for (int k = 1; k <= 84; k++) begin
            @(posedge clk); #1;
            if (mul_done) begin
                if (n_done < 3) begin
                    check("b2b_result", mul_result_754, exp_b2b[n_done]);
                    check("b2b_done_cycle", k, 28 * n_done + 27);
                end
                n_done++;
            end
            if (k % 28 == 1) begin
                opa = op_a_b2b[k / 28];
                opb = op_b_b2b[k / 28];
            end else begin
                opa = $urandom;
                opb = $urandom;
            end
            if (k == 84) mul_start = 1'b0;
        end
        check("b2b_count", n_done, 32'd3);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (mul_busy || mul_done) extra++;
        end
        check("b2b_no_extra", extra, 32'd0);

        // Reset asserted during EXE iteration 10 (cycle starting at E0+12).
        mul_start = 1'b1;
        opa = 32'h4049_0FDB;
        opb = 32'h4000_0000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) mul_start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", {31'b0, mul_busy}, 32'd0);
        check("midrst_done", {31'b0, mul_done}, 32'd0);
        check("midrst_result", mul_result_754, 32'h0);
        rst = 1'b0;
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (mul_done || mul_busy) extra++;
        end
        check("midrst_no_done", extra, 32'd0);
        run_op("after_rst", 32'h4049_0FDB, 32'h4000_0000, 32'h40C9_0FDB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
